bcd_result_display: RTL and testbench

//  Downstream stage of the 2-digit BCD adder/subtractor. Captures its raw result
//  (F2,F1,COUT) and mode (M) on a load strobe, then fixes subtraction complements.

---
 rtl/bcd_result_display.sv | 189 ++++++++++++++++++
 tb/tb_bcd_result_display.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_result_display.sv
// Result stage for a 2-digit BCD adder/subtractor: captures the raw result, undoes
// the subtraction complement digit-wise, and scans sign/hundreds/tens/units onto a 4-digit display.
module bcd_result_display #(
   parameter bit TENS_COMP      = 1'b1,
   parameter int SCAN_DIV       = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] F2,
   input  logic [3:0] F1,
   input  logic       COUT,
   input  logic       M,
   output logic       busy,
   output logic       rdy,
   output logic       neg,
   output logic       err,
   output logic [6:0] seg,
   output logic [3:0] an
);

   typedef enum logic {S_IDLE, S_CONV} state_t;

   localparam logic [3:0] C_DASH  = 4'hA;
   localparam logic [3:0] C_E     = 4'hB;
   localparam logic [3:0] C_BLANK = 4'hF;
   localparam int         CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
   localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

   state_t          r_state, w_state_next;
   logic [3:0]      r_f2, r_f1;
   logic            r_cout, r_m;
   logic [3:0][3:0] r_dig;              // {sign, hundreds, tens, units} glyph codes
   logic            r_neg, r_err, r_rdy;
   logic [CW-1:0]   r_scan_cnt;
   logic [1:0]      r_idx;
   logic [3:0]      r_an;
   logic [6:0]      r_seg;

   logic [3:0]      w_sign, w_hund, w_tens, w_units;
   logic            w_neg, w_err, w_wrap;
   logic [1:0]      w_idx_next;
   logic [6:0]      w_seg_next;

   function automatic logic [6:0] glyph(input logic [3:0] code);
      logic [6:0] g;
      case (code)
         4'd0:    g = 7'b1000000;
         4'd1:    g = 7'b1111001;
         4'd2:    g = 7'b0100100;
         4'd3:    g = 7'b0110000;
         4'd4:    g = 7'b0011001;
         4'd5:    g = 7'b0010010;
         4'd6:    g = 7'b0000010;
         4'd7:    g = 7'b1111000;
         4'd8:    g = 7'b0000000;
         4'd9:    g = 7'b0010000;
         C_DASH:  g = 7'b0111111;
         C_E:     g = 7'b0000110;
         default: g = 7'b1111111;
      endcase
      return g;
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // NOTE: every combinational output is defaulted first so no path can infer a latch.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (load) w_state_next = S_CONV;
         S_CONV:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Complement correction, digit-wise with explicit borrow/carry between units and tens.
   always_comb begin
      w_neg   = 1'b0;
      w_err   = 1'b0;
      w_sign  = C_BLANK;
      w_hund  = C_BLANK;
      w_tens  = r_f2;
      w_units = r_f1;
      if (r_f2 > 4'd9 || r_f1 > 4'd9) begin
         w_err = 1'b1;
      end else if (!r_m) begin
         w_hund = r_cout ? 4'd1 : C_BLANK;
      end else if (TENS_COMP) begin
         if (!r_cout) begin
            if (r_f2 == 4'd0 && r_f1 == 4'd0) begin
               w_err = 1'b1;
            end else begin
               w_neg = 1'b1;
               if (r_f1 == 4'd0) begin
                  w_units = 4'd0;
                  w_tens  = 4'd10 - r_f2;
               end else begin
                  w_units = 4'd10 - r_f1;
                  w_tens  = 4'd9 - r_f2;
               end
            end
         end
      end else begin
         if (r_cout) begin
            if (r_f2 == 4'd9 && r_f1 == 4'd9) begin
               w_err = 1'b1;
            end else if (r_f1 == 4'd9) begin
               w_units = 4'd0;
               w_tens  = r_f2 + 4'd1;
            end else begin
               w_units = r_f1 + 4'd1;
            end
         end else begin
            w_tens  = 4'd9 - r_f2;
            w_units = 4'd9 - r_f1;
            w_neg   = !(r_f2 == 4'd9 && r_f1 == 4'd9);
         end
      end
      if (w_err) begin
         w_neg   = 1'b0;
         w_hund  = C_BLANK;
         w_tens  = C_E;
         w_units = C_E;
      end
      if (w_neg) w_sign = C_DASH;
   end

   // NOTE: capture and digit registers are cleared by reset so an aborted conversion leaves nothing behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_f2   <= '0;
         r_f1   <= '0;
         r_cout <= 1'b0;
         r_m    <= 1'b0;
         r_dig  <= '0;
         r_neg  <= 1'b0;
         r_err  <= 1'b0;
         r_rdy  <= 1'b0;
      end else begin
         r_rdy <= 1'b0;
         if (r_state == S_IDLE && load) begin
            r_f2   <= F2;
            r_f1   <= F1;
            r_cout <= COUT;
            r_m    <= M;
         end
         if (r_state == S_CONV) begin
            r_dig <= {w_sign, w_hund, w_tens, w_units};
            r_neg <= w_neg;
            r_err <= w_err;
            r_rdy <= 1'b1;
         end
      end
   end

   assign w_wrap     = (r_scan_cnt == SCAN_LAST);
   assign w_idx_next = w_wrap ? r_idx + 2'd1 : r_idx;
   assign w_seg_next = SEG_ACTIVE_LOW ? glyph(r_dig[w_idx_next]) : ~glyph(r_dig[w_idx_next]);

   // Free-running scan; an and seg are registered from the same next index so they never skew.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scan_cnt <= '0;
         r_idx      <= 2'd0;
         r_an       <= 4'b1111;
         r_seg      <= SEG_OFF;
      end else begin
         r_scan_cnt <= w_wrap ? '0 : r_scan_cnt + CW'(1);
         r_idx      <= w_idx_next;
         r_an       <= ~(4'b0001 << w_idx_next);
         r_seg      <= w_seg_next;
      end
   end

   assign busy = (r_state == S_CONV);
   assign rdy  = r_rdy;
   assign neg  = r_neg;
   assign err  = r_err;
   assign seg  = r_seg;
   assign an   = r_an;

endmodule

// File: tb/tb_bcd_result_display.sv
// Scoreboarded bench: two instances (10's complement/active-low and 9's complement/active-high)
// share stimulus; an arithmetic model predicts sign, digits, neg and err for each.
module tb_bcd_result_display;

   localparam int SCAN = 4;
   localparam int D_DASH  = 10;
   localparam int D_E     = 11;
   localparam int D_BLANK = 12;

   typedef struct {
      bit neg;
      bit err;
      int ds;
      int dh;
      int dt;
      int du;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic [3:0] f2, f1;
   logic       cout, m;
   logic       busy_a [2];
   logic       rdy_a  [2];
   logic       neg_a  [2];
   logic       err_a  [2];
   logic [6:0] seg_a  [2];
   logic [3:0] an_a   [2];

   int   total = 0;
   int   bad   = 0;
   int   rdy_cnt [2] = '{0, 0};
   int   n_loads = 0;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;

   bcd_result_display #(.TENS_COMP(1'b1), .SCAN_DIV(SCAN), .SEG_ACTIVE_LOW(1'b1)) dut_t (
      .clk(clk), .rst(rst), .load(load), .F2(f2), .F1(f1), .COUT(cout), .M(m),
      .busy(busy_a[0]), .rdy(rdy_a[0]), .neg(neg_a[0]), .err(err_a[0]),
      .seg(seg_a[0]), .an(an_a[0]));

   bcd_result_display #(.TENS_COMP(1'b0), .SCAN_DIV(SCAN), .SEG_ACTIVE_LOW(1'b0)) dut_n (
      .clk(clk), .rst(rst), .load(load), .F2(f2), .F1(f1), .COUT(cout), .M(m),
      .busy(busy_a[1]), .rdy(rdy_a[1]), .neg(neg_a[1]), .err(err_a[1]),
      .seg(seg_a[1]), .an(an_a[1]));

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] glyph(input int code, input int unit);
      logic [6:0] g;
      case (code)
         0:       g = 7'b1000000;
         1:       g = 7'b1111001;
         2:       g = 7'b0100100;
         3:       g = 7'b0110000;
         4:       g = 7'b0011001;
         5:       g = 7'b0010010;
         6:       g = 7'b0000010;
         7:       g = 7'b1111000;
         8:       g = 7'b0000000;
         9:       g = 7'b0010000;
         D_DASH:  g = 7'b0111111;
         D_E:     g = 7'b0000110;
         default: g = 7'b1111111;
      endcase
      return (unit == 0) ? g : ~g;
   endfunction

   function automatic int an_idx(input logic [3:0] a);
      case (a)
         4'b1110: return 0;
         4'b1101: return 1;
         4'b1011: return 2;
         4'b0111: return 3;
         default: return -1;
      endcase
   endfunction

   function automatic int exp_digit(input exp_t e, input int idx);
      case (idx)
         0:       return e.du;
         1:       return e.dt;
         2:       return e.dh;
         default: return e.ds;
      endcase
   endfunction

   // Signed result arithmetic straight from the operand value, then split into decimal digits.
   function automatic exp_t model(input int d2, input int d1, input int c, input int md, input bit tens);
      exp_t e;
      int   f, r, mag;
      e.neg = 1'b0; e.err = 1'b0;
      e.ds = D_BLANK; e.dh = D_BLANK; e.dt = D_E; e.du = D_E;
      if (d2 > 9 || d1 > 9) begin
         e.err = 1'b1;
         return e;
      end
      f = 10 * d2 + d1;
      if (md == 0)       r = 100 * c + f;
      else if (tens) begin
         if (c == 1)      r = f;
         else if (f == 0) begin e.err = 1'b1; return e; end
         else             r = f - 100;
      end else begin
         if (c == 1) begin
            if (f == 99) begin e.err = 1'b1; return e; end
            r = f + 1;
         end else r = f - 99;
      end
      e.neg = (r < 0);
      mag   = (r < 0) ? -r : r;
      e.ds  = e.neg ? D_DASH : D_BLANK;
      e.dh  = (mag >= 100) ? mag / 100 : D_BLANK;
      e.dt  = (mag / 10) % 10;
      e.du  = mag % 10;
      return e;
   endfunction

   task automatic monitor(input int u);
      exp_t     e;
      bit       have;
      bit [3:0] seen;
      int       idx;
      forever begin
         @(negedge clk);
         if (rdy_a[u] === 1'b1) begin
            rdy_cnt[u]++;
            have = (u == 0) ? (q0.size() > 0) : (q1.size() > 0);
            check($sformatf("u%0d rdy_has_pending_load", u), int'(have), 1);
            if (have) begin
               e = (u == 0) ? q0.pop_front() : q1.pop_front();
               check($sformatf("u%0d neg", u), int'(neg_a[u]), int'(e.neg));
               check($sformatf("u%0d err", u), int'(err_a[u]), int'(e.err));
               seen = '0;
               for (int k = 0; k < 5 * SCAN && seen != 4'hF; k++) begin
                  @(negedge clk);
                  idx = an_idx(an_a[u]);
                  if (idx >= 0 && !seen[idx]) begin
                     seen[idx] = 1'b1;
                     check($sformatf("u%0d seg_digit%0d", u, idx), int'(seg_a[u]),
                           int'(glyph(exp_digit(e, idx), u)));
                  end
               end
               check($sformatf("u%0d all_digits_scanned", u), int'(seen), 4'hF);
            end
         end
      end
   endtask

   initial monitor(0);
   initial monitor(1);

   task automatic issue(input logic [3:0] d2, input logic [3:0] d1, input logic c, input logic md,
                        input bit hold2);
      @(negedge clk);
      f2 = d2; f1 = d1; cout = c; m = md; load = 1'b1;
      q0.push_back(model(int'(d2), int'(d1), int'(c), int'(md), 1'b1));
      q1.push_back(model(int'(d2), int'(d1), int'(c), int'(md), 1'b0));
      n_loads++;
      @(negedge clk);
      if (!hold2) load = 1'b0;
      for (int u = 0; u < 2; u++) check($sformatf("u%0d busy_after_load", u), int'(busy_a[u]), 1);
      @(negedge clk);
      load = 1'b0;
      for (int u = 0; u < 2; u++) check($sformatf("u%0d busy_cleared", u), int'(busy_a[u]), 0);
      repeat (24) @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      for (int u = 0; u < 2; u++) begin
         check($sformatf("%s u%0d an", tag, u), int'(an_a[u]), 4'b1111);
         check($sformatf("%s u%0d seg", tag, u), int'(seg_a[u]), (u == 0) ? 7'h7F : 7'h00);
         check($sformatf("%s u%0d busy", tag, u), int'(busy_a[u]), 0);
         check($sformatf("%s u%0d rdy", tag, u), int'(rdy_a[u]), 0);
         check($sformatf("%s u%0d neg", tag, u), int'(neg_a[u]), 0);
         check($sformatf("%s u%0d err", tag, u), int'(err_a[u]), 0);
      end
   endtask

   task automatic scan_test(input int u);
      logic [3:0] s [48];
      logic [6:0] sg [48];
      logic [15:0] run;
      int c0, p, seg_bad;
      exp_t e;
      e = model(5, 4, 1, 0, (u == 0));
      for (int k = 0; k < 48; k++) begin
         @(negedge clk);
         s[k]  = an_a[u];
         sg[k] = seg_a[u];
      end
      c0 = 1;
      while (c0 < 8 && s[c0] == s[c0 - 1]) c0++;
      p = an_idx(s[c0 - 1]);
      check($sformatf("u%0d scan_prev_valid", u), int'(p >= 0), 1);
      if (p < 0) p = 0;
      for (int r = 0; r < 8; r++) begin
         run = {s[c0 + 4*r], s[c0 + 4*r + 1], s[c0 + 4*r + 2], s[c0 + 4*r + 3]};
         check($sformatf("u%0d scan_run%0d", u, r), int'(run),
               int'({4{~(4'b0001 << ((p + 1 + r) % 4))}}));
      end
      seg_bad = 0;
      for (int k = 0; k < 48; k++) begin
         if (an_idx(s[k]) < 0 || sg[k] !== glyph(exp_digit(e, an_idx(s[k])), u)) seg_bad++;
      end
      check($sformatf("u%0d scan_seg_mismatches", u), seg_bad, 0);
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; f2 = '0; f1 = '0; cout = 1'b0; m = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_state("power_on");
      rst = 1'b0;
      repeat (3) @(negedge clk);

      issue(4'd5, 4'd4, 1'b1, 1'b0, 1'b0);
      issue(4'd2, 4'd2, 1'b1, 1'b1, 1'b0);
      issue(4'd7, 4'd8, 1'b0, 1'b1, 1'b0);
      issue(4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
      issue(4'd2, 4'd1, 1'b1, 1'b1, 1'b0);
      issue(4'd7, 4'd7, 1'b0, 1'b1, 1'b0);
      issue(4'd9, 4'd9, 1'b0, 1'b1, 1'b0);
      issue(4'd9, 4'd9, 1'b1, 1'b1, 1'b0);
      issue(4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      issue(4'd0, 4'hC, 1'b0, 1'b0, 1'b1);

      issue(4'd5, 4'd4, 1'b1, 1'b0, 1'b0);
      scan_test(0);
      scan_test(1);

      for (int i = 0; i < 24; i++) begin
         logic [3:0] r2, r1;
         r2 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         r1 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         issue(r2, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      issue(4'd7, 4'd8, 1'b0, 1'b1, 1'b0);
      for (int u = 0; u < 2; u++) check($sformatf("u%0d neg_held", u), int'(neg_a[u]), 1);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_state("mid_scan");
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      f2 = 4'd7; f1 = 4'd8; cout = 1'b0; m = 1'b1; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      for (int u = 0; u < 2; u++) check($sformatf("u%0d busy_before_abort", u), int'(busy_a[u]), 1);
      #2 rst = 1'b1;
      @(negedge clk);
      check_reset_state("abort_conv");
      rst = 1'b0;
      repeat (30) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         check($sformatf("u%0d neg_after_abort", u), int'(neg_a[u]), 0);
         check($sformatf("u%0d rdy_count", u), rdy_cnt[u], n_loads);
      end
      check("u0 pending_left", q0.size(), 0);
      check("u1 pending_left", q1.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
